// File: rtl/ahb_lite_master_arbiter.sv
// Round-robin front end that funnels NUM_REQ local requesters onto one AHB-Lite master port.
// Single transfers only, with overlapped address/data phases, wait states and two-cycle ERROR handling.
`timescale 1ns/1ps
module ahb_lite_master_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  input  logic [NUM_REQ*3-1:0]      req_size,
  output logic [NUM_REQ-1:0]        req_gnt,
  output logic [NUM_REQ-1:0]        req_done,
  output logic                      req_err,
  output logic [DATA_W-1:0]         rdata,
  input  logic                      HREADY,
  input  logic                      HRESP,
  input  logic [DATA_W-1:0]         HRDATA,
  output logic [ADDR_W-1:0]         HADDR,
  output logic                      HWRITE,
  output logic [2:0]                HSIZE,
  output logic [1:0]                HTRANS,
  output logic [2:0]                HBURST,
  output logic [3:0]                HPROT,
  output logic                      HMASTLOCK,
  output logic [DATA_W-1:0]         HWDATA
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {T_IDLE = 2'b00, T_NONSEQ = 2'b10} trans_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              write;
    logic [2:0]        size;
  } aphase_t;

  logic [NUM_REQ-1:0][ADDR_W-1:0] lane_addr;
  logic [NUM_REQ-1:0][DATA_W-1:0] lane_wdata;
  logic [NUM_REQ-1:0][2:0]        lane_size;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
    assign lane_addr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
    assign lane_wdata[gi] = req_wdata[gi*DATA_W +: DATA_W];
    assign lane_size[gi]  = req_size[gi*3 +: 3];
  end

  trans_e              tr_q, tr_d;
  aphase_t             ap_q, ap_d;
  logic [IW-1:0]       a_own_q, a_own_d, d_own_q, d_own_d, last_q, last_d;
  logic                d_vld_q, d_vld_d, d_wr_q, d_wr_d;
  logic [DATA_W-1:0]   wdata_d, rdata_d;
  logic [NUM_REQ-1:0]  gnt_d, done_d;
  logic                err_d;

  logic                accept, d_fin, err_first, slot_free;
  logic [NUM_REQ-1:0]  elig;
  logic [IW-1:0]       base, idx, pick;
  logic [IW:0]         sum;
  logic                pick_vld;

  assign accept    = (tr_q == T_NONSEQ) && HREADY;
  assign d_fin     = d_vld_q && HREADY;
  assign err_first = d_vld_q && HRESP && !HREADY;
  assign slot_free = (tr_q == T_IDLE) || accept;

  // The owner being accepted this edge still shows its old request, so it is masked.
  always_comb begin
    base     = accept ? a_own_q : last_q;
    elig     = req;
    sum      = '0;
    idx      = '0;
    pick     = '0;
    pick_vld = 1'b0;
    if (accept) elig[a_own_q] = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      sum = {1'b0, base} + (IW+1)'(k);
      if (sum >= (IW+1)'(NUM_REQ)) sum = sum - (IW+1)'(NUM_REQ);
      idx = sum[IW-1:0];
      if (elig[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    tr_d    = tr_q;
    ap_d    = ap_q;
    a_own_d = a_own_q;
    d_own_d = d_own_q;
    last_d  = last_q;
    d_vld_d = d_vld_q;
    d_wr_d  = d_wr_q;
    wdata_d = HWDATA;
    rdata_d = rdata;
    gnt_d   = '0;
    done_d  = '0;
    err_d   = 1'b0;

    if (d_fin) begin
      done_d[d_own_q] = 1'b1;
      err_d           = HRESP;
      d_vld_d         = 1'b0;
      if (!d_wr_q) rdata_d = HRDATA;
    end

    if (accept) begin
      gnt_d[a_own_q] = 1'b1;
      last_d         = a_own_q;
      d_vld_d        = 1'b1;
      d_own_d        = a_own_q;
      d_wr_d         = ap_q.write;
      wdata_d        = lane_wdata[a_own_q];
    end

    // First ERROR cycle: drop any pending NONSEQ; the pointer is untouched so it retries first.
    if (err_first) begin
      tr_d = T_IDLE;
    end else if (slot_free) begin
      if (pick_vld) begin
        tr_d       = T_NONSEQ;
        a_own_d    = pick;
        ap_d.addr  = lane_addr[pick];
        ap_d.write = req_write[pick];
        ap_d.size  = lane_size[pick];
      end else begin
        tr_d = T_IDLE;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      tr_q     <= T_IDLE;
      ap_q     <= '0;
      a_own_q  <= '0;
      d_own_q  <= '0;
      last_q   <= IW'(NUM_REQ-1);
      d_vld_q  <= 1'b0;
      d_wr_q   <= 1'b0;
      HWDATA   <= '0;
      rdata    <= '0;
      req_gnt  <= '0;
      req_done <= '0;
      req_err  <= 1'b0;
    end else begin
      tr_q     <= tr_d;
      ap_q     <= ap_d;
      a_own_q  <= a_own_d;
      d_own_q  <= d_own_d;
      last_q   <= last_d;
      d_vld_q  <= d_vld_d;
      d_wr_q   <= d_wr_d;
      HWDATA   <= wdata_d;
      rdata    <= rdata_d;
      req_gnt  <= gnt_d;
      req_done <= done_d;
      req_err  <= err_d;
    end
  end

  assign HTRANS    = tr_q;
  assign HADDR     = ap_q.addr;
  assign HWRITE    = ap_q.write;
  assign HSIZE     = ap_q.size;
  assign HBURST    = 3'b000;
  assign HPROT     = 4'b0011;
  assign HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_ahb_lite_master_arbiter.sv
// Scoreboard bench: requester queues + AHB slave model predict every bus cycle; a monitor pops and compares.
`timescale 1ns/1ps
module tb_ahb_lite_master_arbiter;
  localparam int N = 3, AW = 32, DW = 32;

  logic            HCLK = 1'b0;
  logic            HRESETn;
  logic [N-1:0]    req, req_write, req_gnt, req_done;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N*3-1:0]  req_size;
  logic            req_err, HREADY, HRESP, HWRITE, HMASTLOCK;
  logic [DW-1:0]   rdata, HRDATA, HWDATA;
  logic [AW-1:0]   HADDR;
  logic [2:0]      HSIZE, HBURST;
  logic [1:0]      HTRANS;
  logic [3:0]      HPROT;

  ahb_lite_master_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .req(req), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_size(req_size), .req_gnt(req_gnt), .req_done(req_done),
    .req_err(req_err), .rdata(rdata), .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA),
    .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HTRANS(HTRANS), .HBURST(HBURST),
    .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA));

  always #5 HCLK = ~HCLK;

  typedef struct { logic [AW-1:0] addr; logic write; logic [2:0] size; logic [DW-1:0] wdata; } xfer_t;
  typedef struct { logic trans; logic [AW-1:0] addr; logic write; logic [2:0] size; } exp_a_t;
  typedef struct { int owner; logic [DW-1:0] wdata; } exp_g_t;
  typedef struct { int owner; logic err; logic [DW-1:0] rdata; } exp_d_t;

  xfer_t  rq[N][$];
  exp_a_t qa[$];
  exp_g_t qg[$];
  exp_d_t qd[$];
  int total = 0, bad = 0;

  // stimulus knobs
  int unsigned rdy_pct, err_pct, arr_pct;
  bit          force_err, err_stage, use_fix;
  bit          rdy_script[$];
  logic [DW-1:0] fix_rdata;

  // transaction-level model state
  bit            m_trans, m_dvld, m_dwrite;
  int            m_aowner, m_downer, m_last, pend_pop;
  logic [DW-1:0] m_rdata;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endfunction

  function automatic logic [N-1:0] onehot(int i);
    return N'(1) << i;
  endfunction

  // monitor: one expectation of each kind is due at every post-reset cycle
  exp_a_t ea;
  exp_g_t eg;
  exp_d_t ed;
  always @(posedge HCLK) begin
    #1;
    if (HRESETn) begin
      chk("const_ctrl", {HBURST, HPROT, HMASTLOCK}, {3'b000, 4'b0011, 1'b0});
      if (qa.size() > 0) begin
        ea = qa.pop_front();
        chk("htrans", HTRANS, ea.trans ? 2'b10 : 2'b00);
        if (ea.trans) chk("aphase", {HADDR, HWRITE, HSIZE}, {ea.addr, ea.write, ea.size});
      end
      if (qg.size() > 0) begin
        eg = qg.pop_front();
        chk("gnt", req_gnt, onehot(eg.owner));
        chk("hwdata", HWDATA, eg.wdata);
      end else chk("gnt_idle", req_gnt, '0);
      if (qd.size() > 0) begin
        ed = qd.pop_front();
        chk("done", req_done, onehot(ed.owner));
        chk("err", req_err, ed.err);
        chk("rdata", rdata, ed.rdata);
      end else chk("done_idle", {req_done, req_err}, '0);
    end
  end

  function automatic xfer_t rand_xfer();
    xfer_t x;
    x.addr  = $urandom & 32'hFFFF_FFFC;
    x.write = 1'($urandom_range(1));
    x.size  = 3'($urandom_range(2));
    x.wdata = $urandom;
    return x;
  endfunction

  task automatic push_x(int i, logic [AW-1:0] a, logic w, logic [DW-1:0] d);
    xfer_t x;
    x.addr = a; x.write = w; x.size = 3'b010; x.wdata = d;
    rq[i].push_back(x);
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      req[i] = (rq[i].size() > 0);
      if (rq[i].size() > 0) begin
        req_write[i]           = rq[i][0].write;
        req_addr[i*AW +: AW]   = rq[i][0].addr;
        req_wdata[i*DW +: DW]  = rq[i][0].wdata;
        req_size[i*3 +: 3]     = rq[i][0].size;
      end
    end
  endtask

  task automatic slave_drive();
    HRESP  = 1'b0;
    HREADY = 1'b1;
    HRDATA = use_fix ? fix_rdata : $urandom;
    if (m_dvld) begin
      if (err_stage) begin
        HRESP = 1'b1; HREADY = 1'b1; err_stage = 1'b0;
      end else if (force_err || $urandom_range(99) < err_pct) begin
        HRESP = 1'b1; HREADY = 1'b0; err_stage = 1'b1; force_err = 1'b0;
      end else if (rdy_script.size() > 0) HREADY = rdy_script.pop_front();
      else HREADY = ($urandom_range(99) < rdy_pct);
    end
  endtask

  // What the bus must do after the coming edge, from the rules and the current inputs.
  task automatic model_edge();
    bit acc, dn, e1;
    int prev, pick, j;
    exp_a_t a;
    exp_g_t g;
    exp_d_t d;
    acc  = m_trans && HREADY;
    dn   = m_dvld && HREADY;
    e1   = m_dvld && HRESP && !HREADY;
    prev = m_aowner;
    if (dn) begin
      d.owner = m_downer; d.err = HRESP;
      d.rdata = m_dwrite ? m_rdata : HRDATA;
      m_rdata = d.rdata;
      m_dvld  = 1'b0;
      qd.push_back(d);
    end
    if (acc) begin
      g.owner = prev; g.wdata = rq[prev][0].wdata;
      qg.push_back(g);
      m_dvld = 1'b1; m_downer = prev; m_dwrite = rq[prev][0].write;
      m_last = prev; pend_pop = prev;
    end
    a = '{1'b0, '0, 1'b0, '0};
    if (e1) m_trans = 1'b0;
    else if (!m_trans || acc) begin
      pick = -1;
      for (int k = 1; k <= N; k++) begin
        j = (m_last + k) % N;
        if (pick < 0 && rq[j].size() > 0 && !(acc && j == prev)) pick = j;
      end
      m_trans = (pick >= 0);
      if (pick >= 0) m_aowner = pick;
    end
    if (m_trans) a = '{1'b1, rq[m_aowner][0].addr, rq[m_aowner][0].write, rq[m_aowner][0].size};
    qa.push_back(a);
  endtask

  task automatic step();
    if (pend_pop >= 0) begin
      rq[pend_pop].delete(0);
      pend_pop = -1;
    end
    for (int i = 0; i < N; i++)
      if (rq[i].size() < 3 && $urandom_range(99) < arr_pct) rq[i].push_back(rand_xfer());
    drive_reqs();
    slave_drive();
    model_edge();
    @(negedge HCLK);
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  task automatic reset_model();
    m_trans = 0; m_dvld = 0; m_dwrite = 0; m_aowner = 0; m_downer = 0;
    m_last = N - 1; pend_pop = -1; m_rdata = '0;
    err_stage = 0; force_err = 0; rdy_script.delete();
    for (int i = 0; i < N; i++) rq[i].delete();
    qa.delete(); qg.delete(); qd.delete();
  endtask

  task automatic check_reset(string tag);
    chk({tag, "_htrans"}, HTRANS, 2'b00);
    chk({tag, "_aphase"}, {HADDR, HWRITE, HSIZE}, '0);
    chk({tag, "_hwdata"}, HWDATA, '0);
    chk({tag, "_pulses"}, {req_gnt, req_done, req_err}, '0);
    chk({tag, "_rdata"}, rdata, '0);
  endtask

  function automatic bit busy();
    bit b;
    b = m_trans || m_dvld || (pend_pop >= 0);
    for (int i = 0; i < N; i++) if (rq[i].size() > 0) b = 1'b1;
    return b;
  endfunction

  initial begin
    HRESETn = 1'b0; req = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_size = '0;
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
    rdy_pct = 100; err_pct = 0; arr_pct = 0; use_fix = 0; fix_rdata = '0;
    reset_model();
    repeat (3) @(negedge HCLK);
    check_reset("rst");
    HRESETn = 1'b1;

    // single write, zero wait states
    push_x(0, 32'h100, 1'b1, 32'hA5A5_0001);
    run(6);

    // contention, back-to-back
    push_x(0, 32'h300, 1'b1, 32'h3000_0001); push_x(0, 32'h304, 1'b0, '0);
    push_x(1, 32'h400, 1'b1, 32'h4000_0001); push_x(1, 32'h404, 1'b0, '0);
    run(8);

    // read with three wait states, next NONSEQ held meanwhile
    use_fix = 1; fix_rdata = 32'hDEAD_BEEF;
    rdy_script = '{1'b0, 1'b0, 1'b0, 1'b1};
    push_x(0, 32'h200, 1'b0, '0);
    step();
    push_x(1, 32'h500, 1'b1, 32'h5000_0001);
    run(10);
    use_fix = 0;

    // two-cycle ERROR with another requester's NONSEQ pending
    force_err = 1;
    push_x(0, 32'h600, 1'b0, '0);
    push_x(1, 32'h700, 1'b1, 32'h7000_0001);
    run(10);

    // idle
    run(10);

    // reset during a wait state
    rdy_pct = 0;
    push_x(0, 32'h800, 1'b0, '0);
    for (int t = 0; t < 10 && !m_dvld; t++) step();
    chk("rst_setup", m_dvld, 1'b1);
    step();
    #2 HRESETn = 1'b0;
    #1 check_reset("rst_mid");
    reset_model();
    drive_reqs();
    HREADY = 1'b1; HRESP = 1'b0;
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    rdy_pct = 100;
    push_x(1, 32'h900, 1'b1, 32'h9000_0001);
    run(6);

    // randomized traffic
    rdy_pct = 100; err_pct = 0; arr_pct = 80;
    run(400);
    rdy_pct = 70; err_pct = 6; arr_pct = 35;
    run(1500);
    arr_pct = 0;
    for (int t = 0; t < 300 && busy(); t++) step();
    chk("drain", busy(), 1'b0);
    run(2);
    chk("sb_empty", qa.size() + qg.size() + qd.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
